// File: rtl/bias_relu.sv
// ----------------------------------------------------------------------------
// bias_relu: post-matmul stage of a dense layer.
//   Adds a per-element bias to the packed matmul result vector, one element at
//   a time, through a single shared add_float.  ReLU is optionally applied to
//   each sum.  The result vector feeds the next layer's matmul `a` operand.
//
// Ports
//   clk       clock; all state changes on posedge
//   rst       asynchronous, active-high reset
//   start     1-cycle pulse; latches x/bias and begins (only in idle/done)
//   x         input vector, element 0 at [S*N-1 -: S]
//   bias      bias vector, same packing as x
//   y         registered result vector, same packing
//   busy      high from the cycle after an accepted start until done
//   done      level; high from run completion until the next accepted start
//   nan_flag  sticky per run; set when any element sum is NaN
//
// add_float: multi-cycle IEEE-754 adder (round to nearest even).
//   Operands are captured on start; the result and flags are registered one
//   cycle later, with done pulsed for that single cycle.  Result and flags
//   hold until the next start.  sub=1 computes a - b.
// ----------------------------------------------------------------------------

module add_float #(
    parameter int unsigned FLOAT_WIDTH = 32,
    parameter bit          sub         = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic [FLOAT_WIDTH-1:0] result,
    output logic                   done,
    output logic                   nan,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   zero
);
    localparam int unsigned S = FLOAT_WIDTH;
    localparam int unsigned E = (S == 64) ? 11 : ((S == 16) ? 5 : 8);
    localparam int unsigned M = S - 1 - E;
    // Working mantissa: carry, hidden, fraction, guard/round/sticky.
    localparam int unsigned W = M + 5;
    localparam logic [E-1:0] EMAX = '1;

    logic [S-1:0] a_q, b_q;
    logic         pend_q;

    logic [S-1:0] res_c;
    logic         nan_c, ovf_c, unf_c, zero_c;

    always_comb begin
        logic         sa, sb, sl, ss;
        logic [E-1:0] ea, eb, ef;
        logic [M-1:0] fa, fb;
        logic         a_nan, b_nan, a_inf, b_inf;
        logic [E:0]   el, es, e, d;
        logic [W-1:0] ml, ms, m;
        logic         sticky;
        logic [M+1:0] mr;

        sa    = a_q[S-1];
        ea    = a_q[S-2 -: E];
        fa    = a_q[M-1:0];
        sb    = b_q[S-1] ^ sub;
        eb    = b_q[S-2 -: E];
        fb    = b_q[M-1:0];
        a_nan = (ea == EMAX) && (fa != '0);
        b_nan = (eb == EMAX) && (fb != '0);
        a_inf = (ea == EMAX) && (fa == '0);
        b_inf = (eb == EMAX) && (fb == '0);

        res_c  = '0;
        nan_c  = 1'b0;
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        zero_c = 1'b0;

        // Order operands by magnitude so the subtraction never goes negative.
        if ({ea, fa} >= {eb, fb}) begin
            sl = sa;
            ss = sb;
            el = (ea == '0) ? (E+1)'(1) : {1'b0, ea};
            es = (eb == '0) ? (E+1)'(1) : {1'b0, eb};
            ml = {1'b0, ea != '0, fa, 3'b000};
            ms = {1'b0, eb != '0, fb, 3'b000};
        end else begin
            sl = sb;
            ss = sa;
            el = (eb == '0) ? (E+1)'(1) : {1'b0, eb};
            es = (ea == '0) ? (E+1)'(1) : {1'b0, ea};
            ml = {1'b0, eb != '0, fb, 3'b000};
            ms = {1'b0, ea != '0, fa, 3'b000};
        end

        // Align the smaller operand, folding shifted-out bits into sticky.
        d      = el - es;
        sticky = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (int'(d) > i) begin
                sticky = sticky | ms[0];
                ms     = ms >> 1;
            end
        end
        ms[0] = ms[0] | sticky;

        m = (sl == ss) ? (ml + ms) : (ml - ms);
        e = el;

        if (m[W-1]) begin
            m = {1'b0, m[W-1:2], m[1] | m[0]};
            e = e + 1'b1;
        end

        // Left-normalise; stop at the minimum exponent (subnormal result).
        for (int i = 0; i < int'(W); i++) begin
            if (!m[W-2] && (e > (E+1)'(1))) begin
                m = m << 1;
                e = e - 1'b1;
            end
        end

        mr = {1'b0, m[W-2:3]} + (M+2)'(m[2] & (m[1] | m[0] | m[3]));
        if (mr[M+1]) begin
            mr = mr >> 1;
            e  = e + 1'b1;
        end
        // Hidden bit clear means the result stayed subnormal.
        ef = mr[M] ? e[E-1:0] : '0;

        if (m == '0) begin
            // Exact zero is +0 unless both addends were -0.
            res_c[S-1] = sl & ss;
            zero_c     = 1'b1;
        end else if (e >= {1'b0, EMAX}) begin
            res_c      = {sl, EMAX, {M{1'b0}}};
            ovf_c      = 1'b1;
        end else begin
            res_c      = {sl, ef, mr[M-1:0]};
            unf_c      = !mr[M];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res_c           = '0;
            res_c[S-2 -: E] = EMAX;
            res_c[M-1]      = 1'b1;
            nan_c           = 1'b1;
            ovf_c           = 1'b0;
            unf_c           = 1'b0;
            zero_c          = 1'b0;
        end else if (a_inf || b_inf) begin
            res_c  = {a_inf ? sa : sb, EMAX, {M{1'b0}}};
            ovf_c  = 1'b0;
            unf_c  = 1'b0;
            zero_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            pend_q    <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                pend_q <= 1'b1;
            end else if (pend_q) begin
                pend_q    <= 1'b0;
                result    <= res_c;
                nan       <= nan_c;
                overflow  <= ovf_c;
                underflow <= unf_c;
                zero      <= zero_c;
                done      <= 1'b1;
            end
        end
    end

endmodule

module bias_relu #(
    parameter int unsigned S    = 32,
    parameter int unsigned N    = 4,
    parameter bit          RELU = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S*N-1:0] x,
    input  logic [S*N-1:0] bias,
    output logic [S*N-1:0] y,
    output logic           busy,
    output logic           done,
    output logic           nan_flag
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned E  = (S == 64) ? 11 : ((S == 16) ? 5 : 8);
    localparam int unsigned M  = S - 1 - E;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [S*N-1:0] x_q, bias_q;
    logic [S-1:0]   op_a, op_b, sum, y_elem;
    logic           add_start, add_done, add_nan, sum_is_nan;

    // Element idx sits at the top of the packed vector for idx 0.
    always_comb begin
        op_a = x_q[S*N-1 -: S];
        op_b = bias_q[S*N-1 -: S];
        for (int i = 1; i < int'(N); i++) begin
            if (idx == IW'(i)) begin
                op_a = x_q[(int'(N)-1-i)*int'(S) +: S];
                op_b = bias_q[(int'(N)-1-i)*int'(S) +: S];
            end
        end
    end

    assign add_start = (state == StIssue);

    add_float #(
        .FLOAT_WIDTH (S),
        .sub         (1'b0)
    ) u_add (
        .clk       (clk),
        .rst_n     (~rst),
        .start     (add_start),
        .a         (op_a),
        .b         (op_b),
        .result    (sum),
        .done      (add_done),
        .nan       (add_nan),
        .overflow  (),
        .underflow (),
        .zero      ()
    );

    // NaN passes through ReLU untouched; every other negative (incl. -0) clamps.
    assign sum_is_nan = (&sum[S-2 -: E]) && (|sum[M-1:0]);

    always_comb begin
        y_elem = sum;
        if (RELU && sum[S-1] && !sum_is_nan) begin
            y_elem = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            idx      <= '0;
            x_q      <= '0;
            bias_q   <= '0;
            y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nan_flag <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        x_q      <= x;
                        bias_q   <= bias;
                        idx      <= '0;
                        nan_flag <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= StIssue;
                    end
                end
                StIssue: state <= StWait;
                StWait: begin
                    if (add_done) begin
                        state <= StWrite;
                    end
                end
                StWrite: begin
                    for (int i = 0; i < int'(N); i++) begin
                        if (idx == IW'(i)) begin
                            y[(int'(N)-1-i)*int'(S) +: S] <= y_elem;
                        end
                    end
                    nan_flag <= nan_flag | add_nan;
                    if (idx == IW'(N-1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= StIssue;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_relu.sv
// ----------------------------------------------------------------------------
// tb_bias_relu: bench for bias_relu.
//   Three instances: N=4 with ReLU, N=4 without ReLU, N=1 with ReLU.
//   A vector table drives complete runs; expected results go into a queue
//   when start is pulsed and are popped and compared when done rises.
//   Hand-written sequences cover start-while-busy and reset mid-run.
// ----------------------------------------------------------------------------

module tb_bias_relu;
    localparam int S  = 32;
    localparam int N  = 4;
    localparam int LA = 2;  // add_float cycles from start to done

    logic             clk = 1'b0;
    logic             rst;
    logic             start_r1, start_r0, start_n1;
    logic [S*N-1:0]   x, bias;
    logic [S*N-1:0]   y_r1, y_r0;
    logic             busy_r1, done_r1, nan_r1;
    logic             busy_r0, done_r0, nan_r0;
    logic [S-1:0]     x1, b1, y_n1;
    logic             busy_n1, done_n1, nan_n1;

    always #5 clk = ~clk;

    bias_relu #(.S(S), .N(N), .RELU(1'b1)) dut_r1 (
        .clk(clk), .rst(rst), .start(start_r1), .x(x), .bias(bias),
        .y(y_r1), .busy(busy_r1), .done(done_r1), .nan_flag(nan_r1)
    );

    bias_relu #(.S(S), .N(N), .RELU(1'b0)) dut_r0 (
        .clk(clk), .rst(rst), .start(start_r0), .x(x), .bias(bias),
        .y(y_r0), .busy(busy_r0), .done(done_r0), .nan_flag(nan_r0)
    );

    bias_relu #(.S(S), .N(1), .RELU(1'b1)) dut_n1 (
        .clk(clk), .rst(rst), .start(start_n1), .x(x1), .bias(b1),
        .y(y_n1), .busy(busy_n1), .done(done_n1), .nan_flag(nan_n1)
    );

    typedef struct {
        int           sel;  // 0: N=4 no ReLU, 1: N=4 ReLU, 2: N=1 ReLU
        logic [127:0] x;
        logic [127:0] b;
        logic [127:0] ey;
        logic         en;
    } vec_t;

    typedef struct {
        logic [127:0] y;
        logic         nan;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] C1X = 128'h3F800000_C0000000_3F000000_80000000;
    localparam logic [127:0] C1B = 128'h3F000000_3F800000_BF800000_00000000;
    localparam logic [127:0] C1Y = 128'h3FC00000_00000000_00000000_00000000;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic [127:0] yv, output logic bz,
                          output logic dn, output logic nf);
        case (sel)
            0:       begin yv = y_r0; bz = busy_r0; dn = done_r0; nf = nan_r0; end
            1:       begin yv = y_r1; bz = busy_r1; dn = done_r1; nf = nan_r1; end
            default: begin yv = {y_n1, 96'h0}; bz = busy_n1; dn = done_n1; nf = nan_n1; end
        endcase
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic pulse_start(input int sel);
        @(negedge clk);
        case (sel)
            0:       start_r0 = 1'b1;
            1:       start_r1 = 1'b1;
            default: start_n1 = 1'b1;
        endcase
        @(negedge clk);
        start_r0 = 1'b0;
        start_r1 = 1'b0;
        start_n1 = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.y   = v.ey;
        e.nan = v.en;
        e.lat = ((v.sel == 2) ? 1 : N) * (LA + 2) + 1;
        sb.push_back(e);
    endtask

    // cnt0: negedges elapsed since the accepting posedge (1 = just after it).
    task automatic wait_done(input int sel, input string nm, input int cnt0);
        logic [127:0] yv;
        logic         bz, dn, nf;
        int           cnt;
        exp_t         e;
        cnt = cnt0;
        sample(sel, yv, bz, dn, nf);
        check({nm, " busy_in_run"}, 128'(bz), 128'(1));
        while (!dn && cnt < 400) begin
            @(negedge clk);
            cnt++;
            sample(sel, yv, bz, dn, nf);
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got %0d want 1", nm, sb.size());
        end else begin
            e = sb.pop_front();
            check({nm, " y"}, yv, e.y);
            check({nm, " nan_flag"}, 128'(nf), 128'(e.nan));
            check({nm, " done"}, 128'(dn), 128'(1));
            check({nm, " busy_at_done"}, 128'(bz), 128'(0));
            check({nm, " latency"}, 128'(cnt), 128'(e.lat));
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        x    = v.x;
        bias = v.b;
        x1   = v.x[127:96];
        b1   = v.b[127:96];
        push_exp(v);
        pulse_start(v.sel);
        wait_done(v.sel, nm, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] yv;
        logic         bz, dn, nf;
        vec_t         v;
        int           lows;

        vecs[0]  = '{1, C1X, C1B, C1Y, 1'b0};
        vecs[1]  = '{0, C1X, C1B, 128'h3FC00000_BF800000_BF000000_00000000, 1'b0};
        vecs[2]  = '{1, 128'h7FC00000_C0000000_3F000000_80000000, C1B,
                     128'h7FC00000_00000000_00000000_00000000, 1'b1};
        vecs[3]  = '{1, C1X, C1B, C1Y, 1'b0};
        vecs[4]  = '{0, 128'h40000000_40400000_3F800000_C0400000,
                     128'h40000000_BFC00000_3F800000_3F800000,
                     128'h40800000_3FC00000_40000000_C0000000, 1'b0};
        vecs[5]  = '{1, 128'h40000000_40400000_3F800000_C0400000,
                     128'h40000000_BFC00000_3F800000_3F800000,
                     128'h40800000_3FC00000_40000000_00000000, 1'b0};
        vecs[6]  = '{0, 128'h7F800000_7F800000_00000000_80000000,
                     128'h3F800000_FF800000_00000000_80000000,
                     128'h7F800000_7FC00000_00000000_80000000, 1'b1};
        vecs[7]  = '{1, 128'h7F800000_7F800000_00000000_80000000,
                     128'h3F800000_FF800000_00000000_80000000,
                     128'h7F800000_7FC00000_00000000_00000000, 1'b1};
        vecs[8]  = '{2, 128'hBF800000_00000000_00000000_00000000,
                     128'h3F000000_00000000_00000000_00000000, 128'h0, 1'b0};
        vecs[9]  = '{2, 128'h3F800000_00000000_00000000_00000000,
                     128'h3F000000_00000000_00000000_00000000,
                     128'h3FC00000_00000000_00000000_00000000, 1'b0};
        vecs[10] = '{0, 128'h00000001_3F800000_3F800000_3F800000,
                     128'h00000001_33800000_33800001_B3800000,
                     128'h00000002_3F800000_3F800001_3F7FFFFF, 1'b0};

        rst      = 1'b1;
        start_r1 = 1'b0;
        start_r0 = 1'b0;
        start_n1 = 1'b0;
        x        = '0;
        bias     = '0;
        x1       = '0;
        b1       = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sample(s, yv, bz, dn, nf);
            check($sformatf("reset y sel%0d", s), yv, 128'h0);
            check($sformatf("reset busy sel%0d", s), 128'(bz), 128'(0));
            check($sformatf("reset done sel%0d", s), 128'(dn), 128'(0));
            check($sformatf("reset nan sel%0d", s), 128'(nf), 128'(0));
        end
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start while busy is ignored and the latched inputs are used.
        x    = C1X;
        bias = C1B;
        push_exp(vecs[0]);
        pulse_start(1);
        @(negedge clk);
        @(negedge clk);
        start_r1 = 1'b1;
        x        = 128'h40400000_40400000_40400000_40400000;
        bias     = 128'h40400000_40400000_40400000_40400000;
        @(negedge clk);
        start_r1 = 1'b0;
        wait_done(1, "restart_ignored", 4);
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!done_r1) lows++;
        end
        check("restart_ignored done_held", 128'(lows), 128'(0));
        check("restart_ignored y_held", y_r1, C1Y);

        // Reset during the WAIT of element 2 clears outputs asynchronously.
        x    = 128'h3F800000_3F800000_3F800000_3F800000;
        bias = 128'h3F800000_3F800000_3F800000_3F800000;
        pulse_start(1);
        for (int k = 0; k < 9; k++) @(negedge clk);
        check("midrun y0_written", y_r1, 128'h40000000_40000000_00000000_00000000);
        rst = 1'b1;
        #1;
        check("midrun_rst y", y_r1, 128'h0);
        check("midrun_rst busy", 128'(busy_r1), 128'(0));
        check("midrun_rst done", 128'(done_r1), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
